// File: rtl/kgp_defs_pkg.sv
// Shared KGP core definitions: widths, instruction field positions, opcodes, and the
// fetch state encoding.
package kgp_defs_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned FUNC_W = 11;
  localparam int unsigned LBL_W  = 26;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_MSB  = 25;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_MSB  = 20;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned FUNC_MSB = 10;
  localparam int unsigned LBL_MSB = 25;

  localparam logic [OP_W-1:0] OP_BLTZ = 6'b000111;
  localparam logic [OP_W-1:0] OP_BZ   = 6'b001000;
  localparam logic [OP_W-1:0] OP_BNZ  = 6'b001001;
  localparam logic [OP_W-1:0] OP_BR   = 6'b001010;
  localparam logic [OP_W-1:0] OP_B    = 6'b001011;
  localparam logic [OP_W-1:0] OP_BL   = 6'b001100;
  localparam logic [OP_W-1:0] OP_BCY  = 6'b001101;
  localparam logic [OP_W-1:0] OP_BNCY = 6'b001110;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/branch_target_unit.sv
// Branch resolution for the retiring instruction: evaluates the branch condition,
// forms the target, and selects the next PC.
module branch_target_unit
  import kgp_defs_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  input  logic [LBL_W-1:0] label,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs_data,
  input  logic             carry_flag,
  input  logic             branch,
  input  logic             jumpAddr,
  input  logic             lblSel,
  output logic [XLEN-1:0]  next_pc
);

  logic            taken;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] off16;
  logic [XLEN-1:0] off26;
  logic [XLEN-1:0] target;

  assign seq_pc = pc + XLEN'(4);
  assign off16  = {{(XLEN-IMM_W-2){label[IMM_W-1]}}, label[IMM_W-1:0], 2'b00};
  assign off26  = {{(XLEN-LBL_W-2){label[LBL_W-1]}}, label, 2'b00};

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BLTZ:           taken = rs_data[XLEN-1];
      OP_BZ:             taken = (rs_data == '0);
      OP_BNZ:            taken = (rs_data != '0);
      OP_BR, OP_B, OP_BL: taken = 1'b1;
      OP_BCY:            taken = carry_flag;
      OP_BNCY:           taken = !carry_flag;
      default:           taken = 1'b0;
    endcase
  end

  always_comb begin
    target = seq_pc + off26;
    if (jumpAddr)    target = {rs_data[XLEN-1:2], 2'b00};
    else if (lblSel) target = seq_pc + off16;
  end

  assign next_pc = (branch && taken) ? target : seq_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch / next-PC stage: owns pc and ir, runs the imem handshake, decodes the
// instruction fields, and advances pc when the instruction retires.
module instr_fetch_unit
  import kgp_defs_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [XLEN-1:0]   imem_rdata,
  output logic [OP_W-1:0]   opcode,
  output logic [FUNC_W-1:0] func,
  output logic [REG_W-1:0]  rs,
  output logic [REG_W-1:0]  rt,
  output logic [IMM_W-1:0]  imm,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   link_addr,
  output logic              instr_valid,
  input  logic              branch,
  input  logic              jumpAddr,
  input  logic              lblSel,
  input  logic [XLEN-1:0]   rs_data,
  input  logic              carry_flag,
  input  logic              exec_stall,
  output logic              retire,
  output logic              halted
);

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] next_pc;
  logic            is_halt;

  assign opcode    = ir_q[OP_MSB:OP_LSB];
  assign rs        = ir_q[RS_MSB:RS_LSB];
  assign rt        = ir_q[RT_MSB:RT_LSB];
  assign imm       = ir_q[IMM_MSB:0];
  assign func      = ir_q[FUNC_MSB:0];
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign link_addr = pc_q + XLEN'(4);
  assign is_halt   = (opcode == OP_HALT);

  branch_target_unit u_btu (
    .opcode     (opcode),
    .label      (ir_q[LBL_MSB:0]),
    .pc         (pc_q),
    .rs_data    (rs_data),
    .carry_flag (carry_flag),
    .branch     (branch),
    .jumpAddr   (jumpAddr),
    .lblSel     (lblSel),
    .next_pc    (next_pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // pc and ir; ir only captures responses that arrive while fetching
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
    end else begin
      if (state_q == ST_FETCH && imem_valid) ir_q <= imem_rdata;
      if (retire) pc_q <= next_pc;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (imem_valid) state_d = ST_EXEC;
      ST_EXEC: begin
        if (is_halt)          state_d = ST_HALT;
        else if (!exec_stall) state_d = ST_FETCH;
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode; retire is suppressed while reset is applied
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    retire      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_FETCH: imem_req = 1'b1;
      ST_EXEC: begin
        instr_valid = 1'b1;
        retire      = !is_halt && !exec_stall && !rst;
      end
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit with a memory responder and an
// arithmetic next-PC reference model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [5:0]  opcode;
  logic [10:0] func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        instr_valid;
  logic        branch;
  logic        jumpAddr;
  logic        lblSel;
  logic [31:0] rs_data;
  logic        carry_flag;
  logic        exec_stall;
  logic        retire;
  logic        halted;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .opcode(opcode), .func(func), .rs(rs), .rt(rt), .imm(imm),
    .pc(pc), .link_addr(link_addr), .instr_valid(instr_valid),
    .branch(branch), .jumpAddr(jumpAddr), .lblSel(lblSel),
    .rs_data(rs_data), .carry_flag(carry_flag), .exec_stall(exec_stall),
    .retire(retire), .halted(halted)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mpc;
  logic [31:0] cur_word;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the ISA rules, using plain integer arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] cpc, input logic [31:0] w,
                                             input logic [31:0] rsd, input logic cy,
                                             input logic br, input logic ja, input logic ls);
    int     op;
    bit     taken;
    longint off;
    logic [31:0] tgt;
    op = int'(w[31:26]);
    taken = 0;
    if (br) begin
      if (op == 7)                              taken = rsd[31];
      else if (op == 8)                         taken = (rsd == 0);
      else if (op == 9)                         taken = (rsd != 0);
      else if (op == 10 || op == 11 || op == 12) taken = 1;
      else if (op == 13)                        taken = cy;
      else if (op == 14)                        taken = !cy;
    end
    if (ja) begin
      tgt = (rsd / 4) * 4;
    end else begin
      if (ls) begin
        off = longint'(w[15:0]);
        if (off >= 32768) off -= 65536;
      end else begin
        off = longint'(w[25:0]);
        if (off >= 33554432) off -= 67108864;
      end
      tgt = 32'(longint'(cpc) + 4 + off * 4);
    end
    return taken ? tgt : cpc + 32'd4;
  endfunction

  // Ends in the first cycle after reset release (IDLE), then steps into FETCH
  task automatic do_reset();
    rst = 1'b1; imem_valid = 1'b0; exec_stall = 1'b0;
    branch = 1'b0; jumpAddr = 1'b0; lblSel = 1'b0;
    tick(); tick();
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_iv", instr_valid, 1'b0);
    chk1("rst_retire", retire, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk32("rst_pc", pc, RST_PC);
    chk32("rst_opcode", 32'(opcode), 32'h0);
    chk32("rst_imm", 32'(imm), 32'h0);
    rst = 1'b0;
    mpc = RST_PC;
    #1;
    chk1("idle_no_req", imem_req, 1'b0);
    tick();
  endtask

  // Entered in a FETCH cycle; returns in the EXEC cycle
  task automatic fetch(input logic [31:0] word, input int lat);
    #1;
    chk1("fetch_req", imem_req, 1'b1);
    chk32("fetch_addr", imem_addr, mpc);
    chk1("fetch_iv", instr_valid, 1'b0);
    for (int i = 1; i < lat; i++) begin
      tick(); #1;
      chk1("hold_req", imem_req, 1'b1);
      chk32("hold_addr", imem_addr, mpc);
      chk1("hold_no_retire", retire, 1'b0);
    end
    imem_rdata = word; imem_valid = 1'b1; cur_word = word;
    tick();
    imem_valid = 1'b0; imem_rdata = $urandom;
  endtask

  // Entered in the EXEC cycle; returns in the following FETCH cycle
  task automatic exec(input int stall, input logic [31:0] rsd, input logic cy,
                      input logic br, input logic ja, input logic ls);
    logic [31:0] nxt;
    rs_data = rsd; carry_flag = cy; branch = br; jumpAddr = ja; lblSel = ls;
    for (int i = 0; i < stall; i++) begin
      exec_stall = 1'b1;
      #1;
      chk1("stall_iv", instr_valid, 1'b1);
      chk1("stall_no_retire", retire, 1'b0);
      chk32("stall_pc", pc, mpc);
      tick();
    end
    exec_stall = 1'b0;
    #1;
    chk1("exec_iv", instr_valid, 1'b1);
    chk32("exec_opcode", 32'(opcode), 32'(cur_word[31:26]));
    chk32("exec_rs", 32'(rs), 32'(cur_word[25:21]));
    chk32("exec_rt", 32'(rt), 32'(cur_word[20:16]));
    chk32("exec_imm", 32'(imm), 32'(cur_word[15:0]));
    chk32("exec_func", 32'(func), 32'(cur_word[10:0]));
    chk32("exec_pc", pc, mpc);
    chk32("link_addr", link_addr, mpc + 32'd4);
    chk1("retire", retire, 1'b1);
    nxt = model_next(mpc, cur_word, rsd, cy, br, ja, ls);
    tick();
    branch = 1'b0; jumpAddr = 1'b0; lblSel = 1'b0;
    mpc = nxt;
  endtask

  localparam logic [31:0] W_ADDI = 32'h0C22_0005;
  localparam logic [31:0] W_LW   = 32'h8C43_0008;

  logic [5:0]  r_op;
  logic [31:0] r_word;
  logic [31:0] r_rsd;
  int          r_sel;
  logic        r_br;

  initial begin
    rst = 1'b1; imem_valid = 1'b0; imem_rdata = '0; rs_data = '0; carry_flag = 1'b0;
    exec_stall = 1'b0; branch = 1'b0; jumpAddr = 1'b0; lblSel = 1'b0; cur_word = '0;
    mpc = RST_PC;

    do_reset();
    fetch(W_ADDI, 1);  exec(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
    fetch(W_ADDI, 5);  exec(0, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);

    // bz at 0x10 with imm -2: taken and not taken
    fetch({6'b001010, 5'd2, 21'd0}, 1);       exec(0, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0);
    fetch({6'b001000, 5'd1, 5'd0, 16'hFFFE}, 1); exec(0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    fetch({6'b001010, 5'd2, 21'd0}, 1);       exec(0, 32'h10, 1'b0, 1'b1, 1'b1, 1'b0);
    fetch({6'b001000, 5'd1, 5'd0, 16'hFFFE}, 2); exec(0, 32'h7, 1'b0, 1'b1, 1'b0, 1'b1);

    // br to unaligned register, then bl +3 words from 0x20
    fetch({6'b001010, 5'd2, 21'd0}, 1);       exec(0, 32'h103, 1'b0, 1'b1, 1'b1, 1'b0);
    fetch({6'b001010, 5'd2, 21'd0}, 1);       exec(0, 32'h20, 1'b0, 1'b1, 1'b1, 1'b0);
    fetch({6'b001100, 26'd3}, 1);             exec(0, $urandom, 1'b0, 1'b1, 1'b0, 1'b0);

    fetch(W_LW, 2);  exec(3, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      r_sel  = int'($urandom_range(0, 9));
      r_op   = (r_sel < 8) ? 6'(7 + r_sel) : 6'($urandom_range(0, 6));
      r_word = {r_op, 26'($urandom)};
      r_rsd  = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom);
      r_br   = (r_sel < 8) || ($urandom_range(0, 3) == 0);
      fetch(r_word, int'($urandom_range(1, 4)));
      exec(int'($urandom_range(0, 2)), r_rsd, 1'($urandom), r_br,
           (r_op == 6'd10), (r_op inside {6'd7, 6'd8, 6'd9, 6'd13, 6'd14}));
    end

    // Reset in the middle of a stall: no retire, restart at RST_PC
    fetch(W_LW, 1);
    exec_stall = 1'b1;
    #1; chk1("ms_iv", instr_valid, 1'b1);
    tick();
    rst = 1'b1;
    #1; chk1("ms_rst_no_retire", retire, 1'b0);
    tick();
    rst = 1'b0; exec_stall = 1'b0;
    #1;
    chk1("ms_iv_cleared", instr_valid, 1'b0);
    chk32("ms_pc", pc, RST_PC);
    tick();
    mpc = RST_PC;
    fetch(W_ADDI, 1);  exec(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during FETCH, then a stale response while IDLE
    #1; chk1("mf_req", imem_req, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_valid = 1'b1; imem_rdata = W_ADDI;
    #1;
    chk1("mf_idle_req", imem_req, 1'b0);
    chk32("mf_pc", pc, RST_PC);
    chk1("mf_iv", instr_valid, 1'b0);
    tick();
    imem_valid = 1'b0;
    #1; chk1("mf_stale_ignored", instr_valid, 1'b0);
    mpc = RST_PC;
    fetch(W_ADDI, 1);  exec(0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);

    // Halt
    fetch(32'hFC00_0000, 1);
    #1;
    chk1("halt_iv", instr_valid, 1'b1);
    chk1("halt_no_retire", retire, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("halted", halted, 1'b1);
      chk1("halt_no_req", imem_req, 1'b0);
      chk32("halt_pc", pc, mpc);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
